fetch_stage_ctrl: RTL and testbench
===================================

Name: fetch_stage_ctrl

Overview:
- Front-end responder to the load-use hazard unit's stall requests: owns the PC register and the IF/ID pipeline register.
- Honours PC-write and IF/ID-write enables from the hazard unit, and branch/jump redirect flushes from EX.
- Detects the HALT opcode at fetch, drains the pipeline and freezes fetch.
- Supports a debug single-step mode that gates all front-end advancement.

Parameters:
- PC_WIDTH, 32, width of PC and PC+4 datapath.
- RESET_PC, 32'h0000_0000, PC value after reset.
- HALT_OPCODE, 6'b010101, opcode (instr[31:26]) that halts fetch.
- DRAIN_CYCLES, 4, number of IF/ID-advancing cycles of NOP injection after HALT before O_HALTED asserts.

Ports:
- I_CLK  in  1  system clock, rising edge.
- I_RESET_N  in  1  asynchronous, active-low reset.
- I_PC_WRITE  in  1  from hazard unit; 0 = hold PC (stall).
- I_IFID_WRITE  in  1  from hazard unit; 0 = hold IF/ID contents.
- I_REDIRECT  in  1  taken branch/jump resolved in EX; flush and redirect.
- I_REDIRECT_PC  in  PC_WIDTH  redirect target.
- I_INSTR  in  32  instruction memory read data for O_PC (combinational, same cycle).
- I_DBG_MODE  in  1  1 = step mode.
- I_DBG_STEP  in  1  single-cycle pulse; one advance per pulse while in step mode.
- O_PC  out  PC_WIDTH  current fetch address to instruction memory.
- O_IFID_INSTR  out  32  IF/ID instruction (NOP = 32'h0 when flushed).
- O_IFID_PC4  out  PC_WIDTH  IF/ID PC+4.
- O_IFID_VALID  out  1  IF/ID holds a real instruction.
- O_HALTED  out  1  fetch stopped and pipeline drained.
- O_FETCH_COUNT  out  32  number of valid non-HALT instructions latched into IF/ID.

Behaviour:
- Reset (async, any time, including mid-drain):
  - PC=RESET_PC; O_IFID_INSTR=0, O_IFID_PC4=0, O_IFID_VALID=0.
  - O_HALTED=0; O_FETCH_COUNT=0; state=RUN; drain counter=0.
- Advance enable: adv = !I_DBG_MODE || I_DBG_STEP. When adv=0, every register holds regardless of the other inputs.
- State machine RUN / DRAIN / HALTED; all updates happen at the rising edge when adv=1.
- RUN, priority redirect > stall > normal:
  - I_REDIRECT=1: PC<=I_REDIRECT_PC; IF/ID<=NOP with VALID=0. The flush is applied even if I_IFID_WRITE=0 or I_PC_WRITE=0.
  - Otherwise, I_PC_WRITE=1 advances PC<=PC+4 (wraps modulo 2^PC_WIDTH); I_PC_WRITE=0 holds PC.
  - Otherwise, I_IFID_WRITE=1 loads {I_INSTR, PC+4, VALID=1}; I_IFID_WRITE=0 holds IF/ID.
  - If I_IFID_WRITE=1, no redirect, and I_INSTR[31:26]==HALT_OPCODE: HALT is latched into IF/ID, PC holds even if I_PC_WRITE=1, O_FETCH_COUNT does not increment, state->DRAIN, counter=0.
  - O_FETCH_COUNT increments by 1 (wraps at 2^32) for each valid non-HALT load into IF/ID.
- DRAIN:
  - PC holds.
  - Each adv cycle with I_IFID_WRITE=1 loads IF/ID<=NOP with VALID=0 and increments the counter.
  - Cycles with I_IFID_WRITE=0 hold IF/ID and the counter.
  - When the counter reaches DRAIN_CYCLES: state->HALTED.
  - I_REDIRECT=1 (older branch in EX) cancels the halt: PC<=I_REDIRECT_PC, IF/ID<=NOP, counter=0, state->RUN.
- HALTED:
  - O_HALTED=1; PC and IF/ID frozen (IF/ID=NOP, VALID=0).
  - All inputs except reset are ignored; exit only via reset.
- O_HALTED is registered: it asserts the cycle after entry into HALTED.
- Latency: an instruction presented on I_INSTR appears on O_IFID_* one cycle later.

Decomposition:
- Shared package holds:
  - HALT_OPCODE, NOP_INSTR (32'h0), RESET_PC.
  - State encoding localparams RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - PC_WIDTH default.
- One natural sub-module: if_id_reg (IF/ID register with write-enable, flush, and async active-low reset).
- PC register, FSM and counters stay in fetch_stage_ctrl.

Test Plan:
- Straight-line fetch: release reset, drive sequential non-HALT instructions at 0x0, 0x4, 0x8 -> O_PC 0, 4, 8; O_IFID_PC4 4, 8, 0xC one cycle later; O_FETCH_COUNT=3.
- Load-use stall: at PC=0x10 drive I_PC_WRITE=0, I_IFID_WRITE=0 for 1 cycle -> O_PC stays 0x10 and IF/ID unchanged; next cycle advances to 0x14; count increments once, not twice.
- Redirect during stall: I_REDIRECT=1, I_REDIRECT_PC=0x100, I_PC_WRITE=0, I_IFID_WRITE=0 -> O_PC=0x100, O_IFID_VALID=0, O_IFID_INSTR=0.
- HALT: fetch 0x54000000 at PC=0x20 -> PC holds 0x20; 4 NOP cycles; O_HALTED=1 on the 6th cycle after HALT fetch; later I_REDIRECT ignored.
- Halt cancel: HALT fetched, then I_REDIRECT=1 to 0x200 on the 2nd drain cycle -> state RUN, O_PC=0x200, O_HALTED stays 0.
- Debug step and reset: I_DBG_MODE=1 with 3 I_DBG_STEP pulses spaced 5 cycles apart -> PC advances exactly by 12. Assert I_RESET_N=0 mid-drain asynchronously -> O_PC=RESET_PC, O_HALTED=0, count=0 immediately.

Source files
------------

// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the fetch stage controller.
package fetch_stage_ctrl_pkg;

    localparam int          PC_WIDTH_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE_DEF  = 6'b010101;
    localparam int          DRAIN_CYCLES_DEF = 4;

    // Bubble instruction placed in IF/ID on flush or drain.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef logic [1:0] state_t;
    localparam state_t RUN    = 2'd0;
    localparam state_t DRAIN  = 2'd1;
    localparam state_t HALTED = 2'd2;

    // True when the primary opcode field matches the halt opcode.
    function automatic logic is_halt_instr(input logic [31:0] instr,
                                           input logic [5:0]  halt_op);
        return instr[31:26] == halt_op;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats write-enable, async active-low reset.
module if_id_reg
    import fetch_stage_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic                flush,
    input  logic [31:0]         instr_in,
    input  logic [PC_WIDTH-1:0] pc4_in,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] pc4_o,
    output logic                valid_o
);

    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc4_q, pc4_d;
    logic                valid_q, valid_d;

    // Next contents: bubble on flush, new instruction on load, else hold.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load_en) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end
    end

    // Register storage, cleared to a bubble on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch front end: PC register, IF/ID register, halt drain FSM and debug step gating.
// Nothing moves unless the advance enable is high (run mode, or a step pulse in step mode).
module fetch_stage_ctrl
    import fetch_stage_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(RESET_PC_DEF),
    parameter logic [5:0]          HALT_OPCODE  = HALT_OPCODE_DEF,
    parameter int                  DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                I_CLK,
    input  logic                I_RESET_N,
    input  logic                I_PC_WRITE,
    input  logic                I_IFID_WRITE,
    input  logic                I_REDIRECT,
    input  logic [PC_WIDTH-1:0] I_REDIRECT_PC,
    input  logic [31:0]         I_INSTR,
    input  logic                I_DBG_MODE,
    input  logic                I_DBG_STEP,
    output logic [PC_WIDTH-1:0] O_PC,
    output logic [31:0]         O_IFID_INSTR,
    output logic [PC_WIDTH-1:0] O_IFID_PC4,
    output logic                O_IFID_VALID,
    output logic                O_HALTED,
    output logic [31:0]         O_FETCH_COUNT
);

    localparam int                  CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'(DRAIN_CYCLES);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [31:0]         fetch_count_q, fetch_count_d;
    logic                halted_q, halted_d;

    logic                adv;
    logic                instr_is_halt;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [CNT_W-1:0]    drain_cnt_inc;
    logic                ifid_load;
    logic                ifid_flush;

    assign adv           = !I_DBG_MODE || I_DBG_STEP;
    assign instr_is_halt = is_halt_instr(I_INSTR, HALT_OPCODE);
    assign pc_plus4      = pc_q + PC_STEP;
    assign drain_cnt_inc = drain_cnt_q + CNT_W'(1);

    // State register plus all front-end flops.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            drain_cnt_q   <= '0;
            fetch_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_cnt_q   <= drain_cnt_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
        end
    end

    // Next-state: HALT fetch starts the drain, a redirect cancels it, full drain halts.
    always_comb begin
        state_d = state_q;
        if (adv) begin
            case (state_q)
                RUN: begin
                    if (!I_REDIRECT && I_IFID_WRITE && instr_is_halt) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (I_REDIRECT) begin
                        state_d = RUN;
                    end else if (I_IFID_WRITE && (drain_cnt_inc == DRAIN_LAST)) begin
                        state_d = HALTED;
                    end
                end
                HALTED:  state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
    end

    // Datapath controls: redirect beats stall beats normal advance.
    always_comb begin
        pc_d          = pc_q;
        drain_cnt_d   = drain_cnt_q;
        fetch_count_d = fetch_count_q;
        halted_d      = halted_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        if (adv) begin
            case (state_q)
                RUN: begin
                    if (I_REDIRECT) begin
                        pc_d       = I_REDIRECT_PC;
                        ifid_flush = 1'b1;
                    end else begin
                        ifid_load = I_IFID_WRITE;
                        if (I_IFID_WRITE && instr_is_halt) begin
                            // HALT goes into IF/ID but the PC stays on it.
                            drain_cnt_d = '0;
                        end else begin
                            if (I_PC_WRITE) begin
                                pc_d = pc_plus4;
                            end
                            if (I_IFID_WRITE) begin
                                fetch_count_d = fetch_count_q + 32'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (I_REDIRECT) begin
                        pc_d        = I_REDIRECT_PC;
                        ifid_flush  = 1'b1;
                        drain_cnt_d = '0;
                    end else if (I_IFID_WRITE) begin
                        ifid_flush  = 1'b1;
                        drain_cnt_d = drain_cnt_inc;
                    end
                end
                HALTED: begin
                    // Registered flag rises one cycle after entering HALTED.
                    halted_d = 1'b1;
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_if_id_reg (
        .clk      (I_CLK),
        .rst_n    (I_RESET_N),
        .load_en  (ifid_load),
        .flush    (ifid_flush),
        .instr_in (I_INSTR),
        .pc4_in   (pc_plus4),
        .instr_o  (O_IFID_INSTR),
        .pc4_o    (O_IFID_PC4),
        .valid_o  (O_IFID_VALID)
    );

    assign O_PC          = pc_q;
    assign O_HALTED      = halted_q;
    assign O_FETCH_COUNT = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl with hand-computed expectations.
module tb_fetch_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        dbg_mode;
    logic        dbg_step;
    logic [31:0] o_pc;
    logic [31:0] o_ifid_instr;
    logic [31:0] o_ifid_pc4;
    logic        o_ifid_valid;
    logic        o_halted;
    logic [31:0] o_fetch_count;

    int vectors;
    int miscompares;

    localparam logic [31:0] I0   = 32'h8C01_0000;
    localparam logic [31:0] I1   = 32'h0022_1820;
    localparam logic [31:0] I2   = 32'hAC03_0004;
    localparam logic [31:0] I3   = 32'h2084_0001;
    localparam logic [31:0] I4   = 32'h1000_0003;
    localparam logic [31:0] HALT = 32'h5400_0000;

    fetch_stage_ctrl dut (
        .I_CLK         (clk),
        .I_RESET_N     (rst_n),
        .I_PC_WRITE    (pc_write),
        .I_IFID_WRITE  (ifid_write),
        .I_REDIRECT    (redirect),
        .I_REDIRECT_PC (redirect_pc),
        .I_INSTR       (instr),
        .I_DBG_MODE    (dbg_mode),
        .I_DBG_STEP    (dbg_step),
        .O_PC          (o_pc),
        .O_IFID_INSTR  (o_ifid_instr),
        .O_IFID_PC4    (o_ifid_pc4),
        .O_IFID_VALID  (o_ifid_valid),
        .O_HALTED      (o_halted),
        .O_FETCH_COUNT (o_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr       = I0;
        dbg_mode    = 1'b0;
        dbg_step    = 1'b0;

        // Reset state
        #2;
        check("rst_pc", o_pc, 32'h0);
        check("rst_instr", o_ifid_instr, 32'h0);
        check("rst_pc4", o_ifid_pc4, 32'h0);
        check("rst_valid", {31'b0, o_ifid_valid}, 32'h0);
        check("rst_halted", {31'b0, o_halted}, 32'h0);
        check("rst_count", o_fetch_count, 32'h0);
        #10;
        rst_n = 1'b1;

        // Straight-line fetch at 0x0, 0x4, 0x8
        check("sl_pc0", o_pc, 32'h0);
        tick();
        check("sl_pc1", o_pc, 32'h4);
        check("sl_pc4_0", o_ifid_pc4, 32'h4);
        check("sl_instr0", o_ifid_instr, I0);
        check("sl_valid0", {31'b0, o_ifid_valid}, 32'h1);
        instr = I1;
        tick();
        check("sl_pc2", o_pc, 32'h8);
        check("sl_pc4_1", o_ifid_pc4, 32'h8);
        check("sl_instr1", o_ifid_instr, I1);
        instr = I2;
        tick();
        check("sl_pc3", o_pc, 32'hC);
        check("sl_pc4_2", o_ifid_pc4, 32'hC);
        check("sl_count", o_fetch_count, 32'd3);
        instr = I3;
        tick();
        check("sl_pc_10", o_pc, 32'h10);

        // Load-use stall at 0x10 for one cycle
        instr      = I4;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        tick();
        check("stall_pc", o_pc, 32'h10);
        check("stall_instr", o_ifid_instr, I3);
        check("stall_pc4", o_ifid_pc4, 32'h10);
        check("stall_count", o_fetch_count, 32'd4);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        tick();
        check("unstall_pc", o_pc, 32'h14);
        check("unstall_instr", o_ifid_instr, I4);
        check("unstall_count", o_fetch_count, 32'd5);

        // Redirect while both write enables are low
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        tick();
        check("redir_pc", o_pc, 32'h100);
        check("redir_valid", {31'b0, o_ifid_valid}, 32'h0);
        check("redir_instr", o_ifid_instr, 32'h0);
        check("redir_count", o_fetch_count, 32'd5);
        redirect   = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        instr      = I0;
        tick();
        check("post_redir_pc", o_pc, 32'h104);
        check("post_redir_count", o_fetch_count, 32'd6);

        // Move to 0x20 and fetch HALT there
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        check("to20_pc", o_pc, 32'h20);
        redirect = 1'b0;
        instr    = HALT;
        tick();
        check("halt_pc", o_pc, 32'h20);
        check("halt_instr", o_ifid_instr, HALT);
        check("halt_valid", {31'b0, o_ifid_valid}, 32'h1);
        check("halt_count", o_fetch_count, 32'd6);
        instr = I1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_pc", o_pc, 32'h20);
            check("drain_valid", {31'b0, o_ifid_valid}, 32'h0);
            check("drain_halted", {31'b0, o_halted}, 32'h0);
        end
        tick();
        check("halted_set", {31'b0, o_halted}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        check("halted_pc", o_pc, 32'h20);
        check("halted_hold", {31'b0, o_halted}, 32'h1);
        check("halted_valid", {31'b0, o_ifid_valid}, 32'h0);
        check("halted_count", o_fetch_count, 32'd6);
        redirect = 1'b0;

        // Async reset out of HALTED
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_pc", o_pc, 32'h0);
        check("rst2_halted", {31'b0, o_halted}, 32'h0);
        check("rst2_count", o_fetch_count, 32'h0);
        #3;
        rst_n = 1'b1;

        // Halt cancelled by redirect on the 2nd drain cycle
        instr = HALT;
        tick();
        check("hc_pc", o_pc, 32'h0);
        instr = I2;
        tick();
        check("hc_drain1_valid", {31'b0, o_ifid_valid}, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        check("hc_redir_pc", o_pc, 32'h200);
        check("hc_redir_halted", {31'b0, o_halted}, 32'h0);
        redirect = 1'b0;
        tick();
        check("hc_run_pc", o_pc, 32'h204);
        check("hc_run_pc4", o_ifid_pc4, 32'h204);
        check("hc_run_count", o_fetch_count, 32'd1);
        repeat (5) tick();
        check("hc_late_halted", {31'b0, o_halted}, 32'h0);
        check("hc_late_pc", o_pc, 32'h218);
        check("hc_late_count", o_fetch_count, 32'd6);

        // Debug single-step: three pulses five cycles apart
        dbg_mode = 1'b1;
        dbg_step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dbg_step = 1'b1;
            tick();
            dbg_step = 1'b0;
            check("dbg_step_pc", o_pc, 32'h218 + 32'(4 * (i + 1)));
            repeat (4) tick();
            check("dbg_idle_pc", o_pc, 32'h218 + 32'(4 * (i + 1)));
        end
        check("dbg_count", o_fetch_count, 32'd9);
        dbg_mode = 1'b0;

        // Reset asserted mid-drain
        instr = HALT;
        tick();
        check("md_halt_pc", o_pc, 32'h224);
        instr = I3;
        tick();
        check("md_drain_pc", o_pc, 32'h224);
        #2;
        rst_n = 1'b0;
        #1;
        check("md_rst_pc", o_pc, 32'h0);
        check("md_rst_halted", {31'b0, o_halted}, 32'h0);
        check("md_rst_count", o_fetch_count, 32'h0);
        check("md_rst_valid", {31'b0, o_ifid_valid}, 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        check("md_run_pc", o_pc, 32'h4);
        check("md_run_count", o_fetch_count, 32'd1);

        // PC wraps modulo 2^32
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        check("wrap_redir_pc", o_pc, 32'hFFFF_FFFC);
        redirect = 1'b0;
        tick();
        check("wrap_pc", o_pc, 32'h0);
        check("wrap_pc4", o_ifid_pc4, 32'h0);
        check("wrap_count", o_fetch_count, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
